// File: rtl/isim_sifrele_seri.sv
// rtl/isim_sifrele_seri.sv - serial name signature: rotate-xor over ISIM_LEN chars, space padded.
// Optional sifre_parite output when SIFRE_PARITE_EN is defined.
module isim_sifrele_seri #(
  parameter int                   ISIM_LEN  = 8,
  parameter int                   SIFRE_W   = 8,
  parameter logic [SIFRE_W-1:0]   BASLANGIC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         isim_karakter,
  input  logic               karakter_gecerli,
  input  logic               son,
  output logic               karakter_hazir,
  output logic [SIFRE_W-1:0] sifre,
  output logic               sifre_gecerli,
`ifdef SIFRE_PARITE_EN
  output logic               sifre_parite,
`endif
  input  logic               sifre_hazir
);

  localparam int CNT_W = (ISIM_LEN > 1) ? $clog2(ISIM_LEN) : 1;
  localparam logic [CNT_W-1:0] SON_POZ = CNT_W'(ISIM_LEN - 1);
  localparam logic [7:0]       BOSLUK  = 8'd32;

  typedef enum logic [1:0] {
    TOPLA  = 2'd0,
    DOLDUR = 2'd1,
    HAZIR  = 2'd2
  } durum_t;

  durum_t             durum_q, durum_d;
  logic [CNT_W-1:0]   poz_q, poz_d;
  logic [SIFRE_W-1:0] acc_q, acc_d;
  logic [SIFRE_W-1:0] sifre_q, sifre_d;
  logic               kabul;
  logic [7:0]         islenen;
  logic [SIFRE_W-1:0] acc_yeni;

  assign kabul    = karakter_gecerli && (durum_q == TOPLA);
  assign islenen  = (durum_q == DOLDUR) ? BOSLUK : isim_karakter;
  assign acc_yeni = {acc_q[SIFRE_W-2:0], acc_q[SIFRE_W-1]} ^ SIFRE_W'(islenen);

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q <= TOPLA;
      poz_q   <= '0;
      acc_q   <= BASLANGIC;
      sifre_q <= '0;
    end else begin
      durum_q <= durum_d;
      poz_q   <= poz_d;
      acc_q   <= acc_d;
      sifre_q <= sifre_d;
    end
  end

  // Next state plus datapath; sifre is only written on the edge that enters HAZIR.
  always_comb begin
    durum_d = durum_q;
    poz_d   = poz_q;
    acc_d   = acc_q;
    sifre_d = sifre_q;
    unique case (durum_q)
      TOPLA: begin
        if (kabul) begin
          acc_d = acc_yeni;
          if (poz_q == SON_POZ) begin
            durum_d = HAZIR;
            sifre_d = acc_yeni;
          end else begin
            poz_d = poz_q + 1'b1;
            if (son) durum_d = DOLDUR;
          end
        end
      end
      DOLDUR: begin
        acc_d = acc_yeni;
        if (poz_q == SON_POZ) begin
          durum_d = HAZIR;
          sifre_d = acc_yeni;
        end else begin
          poz_d = poz_q + 1'b1;
        end
      end
      HAZIR: begin
        if (sifre_hazir) begin
          durum_d = TOPLA;
          poz_d   = '0;
          acc_d   = BASLANGIC;
        end
      end
      default: begin
        durum_d = TOPLA;
        poz_d   = '0;
        acc_d   = BASLANGIC;
      end
    endcase
  end

  always_comb begin
    karakter_hazir = (durum_q == TOPLA);
    sifre_gecerli  = (durum_q == HAZIR);
    sifre          = sifre_q;
  end

`ifdef SIFRE_PARITE_EN
  logic parite_q;

  always_ff @(posedge clk) begin
    if (rst)
      parite_q <= 1'b0;
    else
      parite_q <= ^sifre_d;
  end

  assign sifre_parite = parite_q;
`endif

endmodule

// File: tb/tb_isim_sifrele_seri.sv
// tb/tb_isim_sifrele_seri.sv - directed bench for isim_sifrele_seri, default parameters.
// Parity checks compile in when SIFRE_PARITE_EN is defined.
module tb_isim_sifrele_seri;

  logic       clk;
  logic       rst;
  logic [7:0] isim_karakter;
  logic       karakter_gecerli;
  logic       son;
  logic       karakter_hazir;
  logic [7:0] sifre;
  logic       sifre_gecerli;
  logic       sifre_hazir;
`ifdef SIFRE_PARITE_EN
  logic       sifre_parite;
`endif

  int toplam = 0;
  int hatali = 0;

  isim_sifrele_seri dut (
    .clk              (clk),
    .rst              (rst),
    .isim_karakter    (isim_karakter),
    .karakter_gecerli (karakter_gecerli),
    .son              (son),
    .karakter_hazir   (karakter_hazir),
    .sifre            (sifre),
    .sifre_gecerli    (sifre_gecerli),
`ifdef SIFRE_PARITE_EN
    .sifre_parite     (sifre_parite),
`endif
    .sifre_hazir      (sifre_hazir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    toplam++;
    if (gozlenen !== beklenen) begin
      hatali++;
      $display("FAIL %s: got=%h exp=%h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  // One character, waiting (bounded) for karakter_hazir first.
  task automatic gonder(input logic [7:0] c, input logic s);
    int n = 0;
    while (!karakter_hazir && n < 20) begin
      adim();
      n++;
    end
    if (n >= 20) kontrol("hazir_zaman_asimi", 32'(karakter_hazir), 32'd1);
    isim_karakter    = c;
    son              = s;
    karakter_gecerli = 1'b1;
    adim();
    karakter_gecerli = 1'b0;
    son              = 1'b0;
  endtask

  task automatic sekiz_bir(input logic son_son);
    for (int i = 0; i < 7; i++) gonder(8'h01, 1'b0);
    kontrol("yedi_sonra_gecerli", 32'(sifre_gecerli), 32'd0);
    gonder(8'h01, son_son);
  endtask

  initial begin
    int doldur_say;
    rst = 1'b1;
    isim_karakter = 8'h00;
    karakter_gecerli = 1'b0;
    son = 1'b0;
    sifre_hazir = 1'b0;
    adim();
    adim();
    kontrol("reset_hazir", 32'(karakter_hazir), 32'd1);
    kontrol("reset_gecerli", 32'(sifre_gecerli), 32'd0);
    kontrol("reset_sifre", 32'(sifre), 32'h00);
    rst = 1'b0;

    // Eight 0x01 with the consumer always ready.
    sifre_hazir = 1'b1;
    sekiz_bir(1'b0);
    kontrol("varsayilan_gecerli", 32'(sifre_gecerli), 32'd1);
    kontrol("varsayilan_sifre", 32'(sifre), 32'hFF);
    kontrol("varsayilan_hazir_dusuk", 32'(karakter_hazir), 32'd0);
`ifdef SIFRE_PARITE_EN
    kontrol("parite_ff", 32'(sifre_parite), 32'd0);
`endif
    adim();
    kontrol("tek_cevrim_gecerli", 32'(sifre_gecerli), 32'd0);
    kontrol("topla_donus", 32'(karakter_hazir), 32'd1);
    kontrol("sifre_tutulur", 32'(sifre), 32'hFF);

    // 'A' with son -> 7 pad cycles -> 0x4F, consumer stalled afterwards.
    sifre_hazir = 1'b0;
    gonder(8'h41, 1'b1);
    doldur_say = 0;
    for (int i = 0; i < 12 && !sifre_gecerli; i++) begin
      if (karakter_hazir) kontrol("doldur_hazir", 32'(karakter_hazir), 32'd0);
      doldur_say++;
      adim();
    end
    kontrol("doldur_sayisi", 32'(doldur_say), 32'd7);
    kontrol("doldur_sifre", 32'(sifre), 32'h4F);
    kontrol("doldur_gecerli", 32'(sifre_gecerli), 32'd1);
`ifdef SIFRE_PARITE_EN
    kontrol("parite_4f", 32'(sifre_parite), 32'd1);
`endif

    // Backpressure: five stalled cycles with ignored character pulses.
    for (int i = 0; i < 5; i++) begin
      isim_karakter    = 8'h55;
      karakter_gecerli = 1'b1;
      adim();
      kontrol("bekle_sifre", 32'(sifre), 32'h4F);
      kontrol("bekle_gecerli", 32'(sifre_gecerli), 32'd1);
    end
    karakter_gecerli = 1'b0;
    sifre_hazir = 1'b1;
    adim();
    kontrol("birak_gecerli", 32'(sifre_gecerli), 32'd0);
    sekiz_bir(1'b0);
    kontrol("birak_sonra_sifre", 32'(sifre), 32'hFF);
    adim();

    // Reset in the middle of a name.
    for (int i = 0; i < 3; i++) gonder(8'h01, 1'b0);
    rst = 1'b1;
    adim();
    rst = 1'b0;
    kontrol("ara_reset_hazir", 32'(karakter_hazir), 32'd1);
    kontrol("ara_reset_gecerli", 32'(sifre_gecerli), 32'd0);
    kontrol("ara_reset_sifre", 32'(sifre), 32'h00);
    sekiz_bir(1'b0);
    kontrol("ara_reset_sonra", 32'(sifre), 32'hFF);
    kontrol("ara_reset_sonra_gecerli", 32'(sifre_gecerli), 32'd1);
    adim();

    // son on the eighth character: straight to HAZIR.
    sekiz_bir(1'b1);
    kontrol("son8_gecerli", 32'(sifre_gecerli), 32'd1);
    kontrol("son8_sifre", 32'(sifre), 32'hFF);
    adim();
    kontrol("son8_donus", 32'(karakter_hazir), 32'd1);

    $display("test done: total=%0d bad=%0d", toplam, hatali);
    $finish;
  end

endmodule

// File: doc/isim_sifrele_seri.md
ISIM_SIFRELE_SERI -- requirements
Module: isim_sifrele_seri

Interface
REQ-001 SHALL have parameter ISIM_LEN, default 8, characters per name (>=1).
REQ-002 SHALL have parameter SIFRE_W, default 8, signature width in bits (>=8).
REQ-003 SHALL have parameter BASLANGIC, default 0, SIFRE_W-bit accumulator seed.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port isim_karakter  input  8  ASCII character.
REQ-007 SHALL have port karakter_gecerli  input  1  character valid.
REQ-008 SHALL have port son  input  1  marks accepted character as last of a short name.
REQ-009 SHALL have port karakter_hazir  output  1  block accepts a character.
REQ-010 SHALL have port sifre  output  SIFRE_W  completed signature.
REQ-011 SHALL have port sifre_gecerli  output  1  signature valid.
REQ-012 SHALL have port sifre_hazir  input  1  consumer accepts signature.

Function
REQ-013 SHALL implement states TOPLA (accept), DOLDUR (pad), HAZIR (present); karakter_hazir = 1 only in TOPLA; sifre_gecerli = 1 only in HAZIR.
REQ-014 SHALL accept a character only on cycles with karakter_gecerli & karakter_hazir; son is ignored on other cycles.
REQ-015 SHALL update per processed character c: acc <= rotate_left(acc,1) XOR zero_extend(c, SIFRE_W).
REQ-016 SHALL keep a position counter 0..ISIM_LEN-1 counting processed characters (accepted or padded).
REQ-017 SHALL, on acceptance of the ISIM_LEN-th character (son ignored), go TOPLA->HAZIR; sifre_gecerli is high the following cycle.
REQ-018 SHALL, on acceptance with son=1 at position k < ISIM_LEN-1, go TOPLA->DOLDUR and process one pad character 8'd32 per cycle for ISIM_LEN-1-k cycles, then enter HAZIR.
REQ-019 SHALL load sifre with the final accumulator value on entry to HAZIR and hold sifre and sifre_gecerli stable until sifre_hazir=1.
REQ-020 SHALL, on sifre_gecerli & sifre_hazir, return to TOPLA next cycle with acc=BASLANGIC and counter=0; sifre retains its last value.
REQ-021 SHALL ignore sifre_hazir outside HAZIR and karakter_gecerli outside TOPLA (no data loss, no state change).
REQ-022 SHALL give latency of one clock from final processed character to sifre_gecerli; back-to-back names allow one character per cycle except during DOLDUR/HAZIR.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set state TOPLA, counter 0, acc BASLANGIC, sifre 0, sifre_gecerli 0, karakter_hazir 1 (after edge).
REQ-024 SHALL abort any partial name or pending signature when reset is asserted mid-operation; no signature for the aborted name is ever presented.

Configuration
REQ-025 SHALL, with macro SIFRE_PARITE_EN defined, provide output sifre_parite (1 bit) = XOR of all sifre bits, registered with sifre, reset 0.
REQ-026 SHALL, without SIFRE_PARITE_EN, omit the sifre_parite port and logic entirely; all other behaviour identical.

Verification
REQ-027 SHALL verify defaults: eight chars 8'h01, son=0, sifre_hazir=1 -> sifre=8'hFF, sifre_gecerli high exactly one cycle after 8th acceptance.
REQ-028 SHALL verify padding: single char 8'h41 with son=1 -> 7 DOLDUR cycles, karakter_hazir low, then sifre=8'h4F.
REQ-029 SHALL verify backpressure: sifre_hazir=0 for 5 cycles in HAZIR -> sifre/sifre_gecerli stable, karakter_gecerli pulses ignored, next name after release hashes from BASLANGIC.
REQ-030 SHALL verify reset mid-name: 3 chars accepted, rst pulsed 1 cycle -> outputs at reset values; following eight 8'h01 chars -> 8'hFF.
REQ-031 SHALL verify son on 8th char: eight 8'h01 with son=1 on last -> no DOLDUR cycle, sifre=8'hFF.
REQ-032 SHALL verify with SIFRE_PARITE_EN defined: sifre=8'h4F -> sifre_parite=1; sifre=8'hFF -> sifre_parite=0.
